simd_cs_accum: RTL and testbench



---
 rtl/simd_cs_accum_pkg.sv | 42 ++++
 rtl/simd_csa42.sv | 22 ++
 rtl/simd_cs_accum.sv | 171 +++++++++++++++++
 tb/tb_simd_cs_accum.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/simd_cs_accum_pkg.sv
// Shared types, constants and lane-boundary helpers for the SIMD carry-save accumulator.
package simd_cs_accum_pkg;

  localparam int unsigned PrngW = 256;
  typedef logic [PrngW-1:0] prng_t;

  localparam logic [2:0] MODE_ARITH = 3'b100;
  localparam logic [2:0] MODE_BOOL  = 3'b010;

  localparam logic [2:0] WIDTH_32  = 3'b000;
  localparam logic [2:0] WIDTH_64  = 3'b001;
  localparam logic [2:0] WIDTH_128 = 3'b011;
  localparam logic [2:0] WIDTH_256 = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StResLo,
    StResHi,
    StOut
  } cs_acc_state_t;

  // Bit b-1 set means the carry crossing 32-bit boundary b (b = 1..7) is passed.
  function automatic logic [6:0] lane_carry_mask(input logic [2:0] width);
    logic [6:0] m;
    for (int b = 1; b <= 7; b++) begin
      m[b-1] = ((b % 2 == 1) & width[0]) | ((b % 4 == 2) & width[1]) | ((b == 4) & width[2]);
    end
    return m;
  endfunction

  // Shift a carry vector up one bit, dropping carries at killed lane boundaries.
  function automatic prng_t carry_shift(input prng_t x, input logic [6:0] mask);
    prng_t r;
    r = {x[PrngW-2:0], 1'b0};
    for (int b = 1; b <= 7; b++) begin
      if (!mask[b-1]) r[32*b] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/simd_csa42.sv
// Combinational 256-bit 4:2 compressor built from two 3:2 stages with lane carry kill.
module simd_csa42
  import simd_cs_accum_pkg::*;
(
  input  prng_t      a_i,
  input  prng_t      b_i,
  input  prng_t      c_i,
  input  prng_t      d_i,
  input  logic [6:0] mask_i,
  output prng_t      sum_o,
  output prng_t      carry_o
);

  prng_t s1;
  prng_t c1;

  assign s1      = a_i ^ b_i ^ c_i;
  assign c1      = carry_shift((a_i & b_i) | (a_i & c_i) | (b_i & c_i), mask_i);
  assign sum_o   = s1 ^ c1 ^ d_i;
  assign carry_o = carry_shift((s1 & c1) | (s1 & d_i) | (c1 & d_i), mask_i);

endmodule

// File: rtl/simd_cs_accum.sv
// Carry-save accumulator over simd_muland ps/sc beats with a two-cycle segmented resolve.
module simd_cs_accum
  import simd_cs_accum_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  prng_t            ps_i,
  input  prng_t            sc_i,
  input  logic [2:0]       mode_i,
  input  logic [2:0]       width_i,
  input  logic [CNT_W-1:0] n_terms_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output prng_t            result_o
);

  cs_acc_state_t    state_q, state_d;
  prng_t            acc_s_q, acc_s_d;
  prng_t            acc_c_q, acc_c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             arith_q, arith_d;
  logic [2:0]       width_q, width_d;
  logic             carry_q, carry_d;
  logic [127:0]     res_lo_q, res_lo_d;
  prng_t            result_q, result_d;
  logic             out_valid_q, out_valid_d;

  logic       accept;
  logic [6:0] mask;
  prng_t      csa_sum;
  prng_t      csa_carry;

  assign in_ready_o  = ~rst_i & ((state_q == StIdle) | (state_q == StAccum));
  assign accept      = in_valid_i & in_ready_o;
  assign mask        = lane_carry_mask(width_q);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

  simd_csa42 u_csa42 (
    .a_i    (acc_s_q),
    .b_i    (acc_c_q),
    .c_i    (ps_i),
    .d_i    (sc_i),
    .mask_i (mask),
    .sum_o  (csa_sum),
    .carry_o(csa_carry)
  );

  // One 128-bit segmented adder serves both resolve cycles; the half is chosen by state.
  logic         add_hi;
  logic [127:0] add_a, add_b, add_sum;
  logic         add_cout;
  logic         cy;
  logic [32:0]  seg;
  int           idx;

  always_comb begin
    add_hi  = (state_q == StResHi);
    add_a   = add_hi ? acc_s_q[255:128] : acc_s_q[127:0];
    add_b   = add_hi ? acc_c_q[255:128] : acc_c_q[127:0];
    add_sum = '0;
    cy      = add_hi ? carry_q : 1'b0;
    seg     = '0;
    idx     = 0;
    for (int j = 0; j < 4; j++) begin
      idx = (add_hi ? 4 : 0) + j - 1;
      if (j > 0 && !mask[idx]) cy = 1'b0;
      seg = {1'b0, add_a[32*j +: 32]} + {1'b0, add_b[32*j +: 32]} + {32'b0, cy};
      add_sum[32*j +: 32] = seg[31:0];
      cy = seg[32];
    end
    add_cout = cy;
  end

  always_comb begin
    state_d     = state_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    arith_d     = arith_q;
    width_d     = width_q;
    carry_d     = carry_q;
    res_lo_d    = res_lo_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          arith_d = (mode_i == MODE_ARITH);
          width_d = width_i;
          n_d     = (n_terms_i == '0) ? CNT_W'(1) : n_terms_i;
          cnt_d   = CNT_W'(1);
          if (mode_i == MODE_ARITH) begin
            acc_s_d = ps_i;
            acc_c_d = sc_i;
          end else begin
            acc_s_d = ps_i ^ sc_i;
            acc_c_d = '0;
          end
          state_d = (n_terms_i <= CNT_W'(1)) ? StResLo : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (arith_q) begin
            acc_s_d = csa_sum;
            acc_c_d = csa_carry;
          end else begin
            acc_s_d = acc_s_q ^ ps_i ^ sc_i;
            acc_c_d = '0;
          end
          if (cnt_q + CNT_W'(1) == n_q) state_d = StResLo;
        end
      end
      StResLo: begin
        res_lo_d = add_sum;
        carry_d  = (width_q == WIDTH_256) & add_cout;
        state_d  = StResHi;
      end
      StResHi: begin
        result_d    = {add_sum, res_lo_q};
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      arith_q     <= 1'b0;
      width_q     <= '0;
      carry_q     <= 1'b0;
      res_lo_q    <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      arith_q     <= arith_d;
      width_q     <= width_d;
      carry_q     <= carry_d;
      res_lo_q    <= res_lo_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_simd_cs_accum.sv
// Directed bench for simd_cs_accum with hand-computed expected results.
module tb_simd_cs_accum;
  import simd_cs_accum_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  prng_t      ps;
  prng_t      sc;
  logic [2:0] mode;
  logic [2:0] width;
  logic [7:0] n_terms;
  logic       out_valid;
  logic       out_ready;
  prng_t      result;

  int total = 0;
  int bad   = 0;

  simd_cs_accum #(.CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .ps_i       (ps),
    .sc_i       (sc),
    .mode_i     (mode),
    .width_i    (width),
    .n_terms_i  (n_terms),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input prng_t obs, input prng_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input prng_t p, input prng_t s);
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) check("beat_ready_timeout", 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    ps       = p;
    sc       = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check(tag, 256'(out_valid), 256'(1));
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handshake_drop", 256'(out_valid), 256'(0));
  endtask

  prng_t exp_v;

  initial begin
    rst = 1'b1; in_valid = 1'b0; ps = '0; sc = '0;
    mode = MODE_ARITH; width = WIDTH_32; n_terms = 8'd1; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_result", result, '0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 256'(in_ready), 256'(1));

    // Width 32: lane 0 wraps to zero, carry must not leak into lane 1.
    mode = MODE_ARITH; width = WIDTH_32; n_terms = 8'd1;
    beat(256'h0000_0000_FFFF_FFFF, 256'h1);
    check("lat_t0", 256'(out_valid), 256'(0));
    tick();
    check("lat_t1", 256'(out_valid), 256'(0));
    tick();
    check("lat_t2", 256'(out_valid), 256'(1));
    check("w32_wrap", result, '0);
    finish_out();

    // Carry across bit 127 only at width 256.
    width = WIDTH_256;
    beat({128'h0, {128{1'b1}}}, 256'h1);
    wait_valid("w256_valid");
    check("w256_carry", result, {127'h0, 1'b1, 128'h0});
    finish_out();
    width = WIDTH_128;
    beat({128'h0, {128{1'b1}}}, 256'h1);
    wait_valid("w128_valid");
    check("w128_kill", result, '0);
    finish_out();

    // Width 64, three gapped beats of all-ones.
    width = WIDTH_64; n_terms = 8'd3;
    beat({4{64'hFFFF_FFFF_FFFF_FFFF}}, '0);
    tick(); tick();
    check("gap_ready", 256'(in_ready), 256'(1));
    beat({4{64'hFFFF_FFFF_FFFF_FFFF}}, '0);
    tick(); tick();
    check("gap_no_out", 256'(out_valid), 256'(0));
    beat({4{64'hFFFF_FFFF_FFFF_FFFF}}, '0);
    wait_valid("w64_valid");
    check("w64_sum3", result, {4{64'hFFFF_FFFF_FFFF_FFFD}});
    finish_out();

    // Boolean, two widths; mid-frame config changes must be ignored.
    mode = MODE_BOOL; width = WIDTH_32; n_terms = 8'd2;
    beat({32{8'hA5}}, {32{8'h0F}});
    mode = MODE_ARITH; width = WIDTH_256; n_terms = 8'd5;
    beat({32{8'hFF}}, {32{8'h00}});
    wait_valid("bool_valid_a");
    check("bool_w32", result, {32{8'h55}});
    finish_out();
    mode = 3'b000; width = WIDTH_256; n_terms = 8'd2;
    beat({32{8'hA5}}, {32{8'h0F}});
    beat({32{8'hFF}}, {32{8'h00}});
    wait_valid("bool_valid_b");
    check("bool_w256", result, {32{8'h55}});
    finish_out();

    // Backpressure; the following frame uses n_terms = 0 (treated as 1).
    mode = MODE_ARITH; width = WIDTH_32; n_terms = 8'd1;
    beat({8{32'h1}}, {8{32'h2}});
    n_terms = 8'd0;
    wait_valid("bp_valid");
    exp_v = {8{32'h3}};
    in_valid = 1'b1; ps = {8{32'h7}}; sc = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_result_hold", result, exp_v);
      check("bp_in_ready", 256'(in_ready), 256'(0));
      check("bp_out_valid", 256'(out_valid), 256'(1));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released", 256'(out_valid), 256'(0));
    check("bp_idle_ready", 256'(in_ready), 256'(1));
    tick();
    in_valid = 1'b0;
    wait_valid("bp_next_valid");
    check("bp_next_result", result, {8{32'h7}});
    finish_out();

    // Reset mid-frame after 2 of 4 beats.
    n_terms = 8'd4;
    beat({8{32'h9}}, '0);
    beat({8{32'h9}}, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 256'(out_valid), 256'(0));
    check("midrst_result", result, '0);
    n_terms = 8'd1;
    beat({8{32'h5}}, '0);
    wait_valid("post_rst_valid");
    check("post_rst_result", result, {8{32'h5}});
    finish_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
